instr_decode_pipe: RTL and testbench

- Registered, parametrised successor to the combinational instruction decoder.
- Accepts instructions over a valid/ready handshake and decodes two formats: R-type (MSB=0) and I-type (MSB=1, with immediate).
- Presents the decoded control bundle to the register file and ALU one cycle later.
- An illegal encoding halts intake in a TRAP state until software clears it.

---
 rtl/decode_pkg.sv | 24 ++
 rtl/decode_comb.sv | 62 ++++++
 rtl/instr_decode_pipe.sv | 109 ++++++++++
 tb/tb_instr_decode_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the pipelined instruction decoder: ALU op codes,
// R-type func codes, I-type op codes and the intake FSM state.
package decode_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_PASS = 4'b1000;
  localparam logic [3:0] ALU_SHOW = 4'b1111;

  // R-type func codes, compared against the zero-extended func field
  localparam int FN_ADD  = 1;
  localparam int FN_SUB  = 2;
  localparam int FN_AND  = 3;
  localparam int FN_OR   = 4;
  localparam int FN_SHOW = 'h12;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational field decoder: splits an instruction word into the
// ALU/register-file control bundle and flags unsupported encodings.
module decode_comb
  import decode_pkg::*;
#(
  parameter int  INSTR_W = 16,
  parameter int  REG_AW  = 3,
  localparam int IMM_W   = INSTR_W - 5 - REG_AW
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         alu_op,
  output logic [REG_AW-1:0]  addr1,
  output logic [REG_AW-1:0]  addr2,
  output logic [IMM_W-1:0]   imm,
  output logic               use_imm,
  output logic               write,
  output logic               show,
  output logic               illegal
);
  localparam int FUNC_W = INSTR_W - 1 - 2*REG_AW;

  logic [FUNC_W-1:0] func;
  logic [3:0]        op;

  assign func = instr[INSTR_W-2:2*REG_AW];
  assign op   = instr[INSTR_W-2 -: 4];

  always_comb begin
    alu_op  = '0;
    addr1   = '0;
    addr2   = '0;
    imm     = '0;
    use_imm = 1'b0;
    write   = 1'b0;
    show    = 1'b0;
    illegal = 1'b0;
    if (!instr[INSTR_W-1]) begin
      addr2 = instr[REG_AW-1:0];
      addr1 = instr[2*REG_AW-1:REG_AW];
      write = 1'b1;
      case (32'(func))
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SHOW: begin alu_op = ALU_SHOW; show = 1'b1; write = 1'b0; end
        default: begin write = 1'b0; illegal = 1'b1; end
      endcase
    end else begin
      addr1   = instr[INSTR_W-6 -: REG_AW];
      imm     = instr[IMM_W-1:0];
      use_imm = 1'b1;
      write   = 1'b1;
      case (op)
        OP_LDI:  alu_op = ALU_PASS;
        OP_ADDI: alu_op = ALU_ADD;
        default: begin use_imm = 1'b0; write = 1'b0; imm = '0; illegal = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered instruction decoder with valid/ready handshake and trap-on-illegal.
// Optional legal-instruction counter enabled by defining DECODE_STATS_EN.
module instr_decode_pipe
  import decode_pkg::*;
#(
  parameter int  INSTR_W = 16,
  parameter int  REG_AW  = 3,
  localparam int IMM_W   = INSTR_W - 5 - REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_alu_op,
  output logic [REG_AW-1:0]  out_addr1,
  output logic [REG_AW-1:0]  out_addr2,
  output logic [IMM_W-1:0]   out_imm,
  output logic               out_use_imm,
  output logic               out_write,
  output logic               out_show,
  output logic               trap,
  output logic [INSTR_W-1:0] trap_instr,
  input  logic               trap_clr,
  output logic [15:0]        instr_count
);
  logic [3:0]        d_alu_op;
  logic [REG_AW-1:0] d_addr1, d_addr2;
  logic [IMM_W-1:0]  d_imm;
  logic              d_use_imm, d_write, d_show, d_illegal;
  state_t            state, state_nxt;
  logic              live, take, take_legal;

  decode_comb #(.INSTR_W(INSTR_W), .REG_AW(REG_AW)) u_dec (
    .instr   (in_instr),
    .alu_op  (d_alu_op),
    .addr1   (d_addr1),
    .addr2   (d_addr2),
    .imm     (d_imm),
    .use_imm (d_use_imm),
    .write   (d_write),
    .show    (d_show),
    .illegal (d_illegal)
  );

  // live keeps in_ready low while reset is held and until the first edge after
  assign in_ready   = live && (state == ST_RUN) && (!out_valid || out_ready);
  assign take       = in_valid && in_ready;
  assign take_legal = take && !d_illegal;
  assign trap       = (state == ST_TRAP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (take && d_illegal) state_nxt = ST_TRAP;
      ST_TRAP: if (trap_clr)          state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      live       <= 1'b0;
      trap_instr <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (take && d_illegal) trap_instr <= in_instr;
    end
  end

  // bundle loads only on a legal transfer; otherwise held until drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_alu_op  <= '0;
      out_addr1   <= '0;
      out_addr2   <= '0;
      out_imm     <= '0;
      out_use_imm <= 1'b0;
      out_write   <= 1'b0;
      out_show    <= 1'b0;
    end else if (take_legal) begin
      out_valid   <= 1'b1;
      out_alu_op  <= d_alu_op;
      out_addr1   <= d_addr1;
      out_addr2   <= d_addr2;
      out_imm     <= d_imm;
      out_use_imm <= d_use_imm;
      out_write   <= d_write;
      out_show    <= d_show;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  instr_count <= '0;
    else if (take_legal && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed + randomized bench for instr_decode_pipe, checked against a
// transaction-level decode model and an output scoreboard.
module tb_instr_decode_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] in_instr = '0, trap_instr, instr_count;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_addr1, out_addr2;
  logic [7:0]  out_imm;
  logic        out_use_imm, out_write, out_show, trap, trap_clr = 1'b0;

  always #5 clk = ~clk;

  instr_decode_pipe #(.INSTR_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_addr1(out_addr1), .out_addr2(out_addr2),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_write(out_write),
    .out_show(out_show), .trap(trap), .trap_instr(trap_instr),
    .trap_clr(trap_clr), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [3:0] alu_op; logic [2:0] a1; logic [2:0] a2; logic [7:0] imm;
    logic use_imm; logic write; logic show;
  } bun_t;

  bun_t        q[$];
  int          n_chk = 0, n_fail = 0;
  logic        m_trap = 1'b0;
  logic [15:0] m_tinstr = '0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode straight from the instruction-set table; returns 1 when legal.
  function automatic logic ref_dec(input logic [15:0] w, output bun_t b);
    int f  = int'(w[14:6]);
    int op = int'(w[14:11]);
    b = '0;
    if (w[15] == 1'b0) begin
      b.a1 = w[5:3]; b.a2 = w[2:0];
      if (f >= 1 && f <= 4) begin b.alu_op = 4'(f); b.write = 1'b1; return 1'b1; end
      if (f == 'h12) begin b.alu_op = 4'hF; b.show = 1'b1; return 1'b1; end
      return 1'b0;
    end
    b.a1 = w[10:8]; b.imm = w[7:0]; b.use_imm = 1'b1; b.write = 1'b1;
    if (op == 0) begin b.alu_op = 4'h8; return 1'b1; end
    if (op == 1) begin b.alu_op = 4'h1; return 1'b1; end
    b = '0;
    return 1'b0;
  endfunction

  // One clock: check visible state, account transfers, advance the model.
  task automatic cyc();
    bun_t b;
    logic nt;
    int   exp_cnt;
    #1;
`ifdef DECODE_STATS_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("out_valid", out_valid, q.size() != 0);
    chk("trap", trap, m_trap);
    chk("trap_instr", trap_instr, m_tinstr);
    chk("in_ready", in_ready, !m_trap && (q.size() == 0 || out_ready));
    chk("instr_count", instr_count, 64'(exp_cnt));
    if (q.size() != 0)
      chk("bundle", {out_alu_op, out_addr1, out_addr2, out_imm, out_use_imm, out_write, out_show}, q[0]);
    nt = m_trap;
    if (m_trap && trap_clr) nt = 1'b0;
    if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    if (in_valid && in_ready) begin
      if (ref_dec(in_instr, b)) begin
        q.push_back(b);
        if (m_cnt < 'hFFFF) m_cnt++;
      end else begin
        m_tinstr = in_instr;
        nt = 1'b1;
      end
    end
    m_trap = nt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_outs", {out_valid, out_alu_op, out_addr1, out_addr2, out_imm, out_use_imm,
                     out_write, out_show, trap, trap_instr, instr_count}, 64'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    q.delete(); m_trap = 1'b0; m_tinstr = '0; m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int fl[5] = '{1, 2, 3, 4, 18};
    in_valid = 1'b0; out_ready = 1'b0; trap_clr = 1'b0;
    do_reset();

    // back-to-back R-type, one bundle per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 16'h0051; cyc();
    chk("add_op", out_alu_op, 4'b0001); chk("add_a1", out_addr1, 3'd2);
    chk("add_a2", out_addr2, 3'd1);     chk("add_wr", out_write, 1'b1);
    in_instr = 16'h0113; cyc(); chk("or_op", out_alu_op, 4'b0100);
    in_instr = 16'h008A; cyc(); chk("sub_op", out_alu_op, 4'b0010);
    in_instr = 16'h00DF; cyc(); chk("and_op", out_alu_op, 4'b0011);
    in_instr = 16'h0483; cyc();
    chk("show_op", out_alu_op, 4'hF); chk("show_strobe", out_show, 1'b1);
    chk("show_wr", out_write, 1'b0);  chk("show_a2", out_addr2, 3'd3);

    // LDI held under backpressure
    in_instr = 16'h85A7; cyc();
    out_ready = 1'b0; in_instr = 16'h0051;
    repeat (3) begin
      cyc();
      chk("ldi_imm", out_imm, 8'hA7); chk("ldi_use_imm", out_use_imm, 1'b1);
      chk("ldi_a1", out_addr1, 3'd5); chk("ldi_stall_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1; in_valid = 1'b0; cyc();

    // illegal R-func traps, clr resumes
    in_valid = 1'b1; in_instr = 16'h0FC1; cyc();
    in_instr = 16'h0051;
    chk("ill_trap", trap, 1'b1); chk("ill_word", trap_instr, 16'h0FC1);
    chk("ill_no_valid", out_valid, 1'b0); chk("ill_ready", in_ready, 1'b0);
    cyc(); cyc();
    trap_clr = 1'b1; cyc(); trap_clr = 1'b0;
    chk("clr_ready", in_ready, 1'b1);
    cyc(); chk("post_clr_add", out_alu_op, 4'b0001);

    // reset with a stalled bundle, then reset while trapped
    out_ready = 1'b0; in_instr = 16'h85A7; cyc();
    chk("pend_valid", out_valid, 1'b1);
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h0FC1; cyc();
    chk("pre_rst_trap", trap, 1'b1);
    do_reset();
    chk("rel_ready", in_ready, 1'b1);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      trap_clr  = $urandom_range(0, 4) == 0;
      case ($urandom_range(0, 7))
        0:       in_instr = 16'($urandom);
        1, 2, 3: in_instr = 16'(32'h8000 | ($urandom_range(0, 1) << 11) | $urandom_range(0, 2047));
        default: in_instr = 16'((fl[$urandom_range(0, 4)] << 6) | $urandom_range(0, 63));
      endcase
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; trap_clr = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
